pwm_duty_capture: RTL
=====================

// Module: pwm_duty_capture
// PURPOSE
//   Receive-side decoder for the heater/fan PWM produced from the 8-bit
//   free-running time base. Synchronises an external PWM line, measures each
//   frame (rising edge to rising edge), and reports high-time and period with
//   a one-cycle valid strobe. Flags a stuck line (no edges) so the cool/heat
//   controller can detect a dead actuator drive.
// PARAMETERS
//   W           8    duty width; nominal frame = 2**W clocks
//   SYNC_STAGES 2    synchroniser flops on pwm_in (>=2)
//   TIMEOUT     512  clocks without a rising edge before stuck is declared (< 2**(W+2))
// PORTS
//   clk        in   1     system clock, all logic on posedge
//   rst        in   1     synchronous, active-high reset
//   pwm_in     in   1     asynchronous PWM line to be decoded
//   duty       out  W     high clocks in last frame, saturates at 2**W-1
//   period     out  W+2   clocks in last frame (rise to rise)
//   valid      out  1     1-cycle strobe: duty/period/stuck updated
//   stuck      out  1     level; 1 = last report was a timeout
// BEHAVIOUR
//   Reset: duty=0, period=0, valid=0, stuck=0, state=SEEK, counters=0,
//     synchroniser and edge flops=0. Reset mid-frame discards the frame, no valid.
//   Sync: pwm_s = pwm_in after SYNC_STAGES flops; pwm_d = pwm_s delayed 1;
//     rise = pwm_s & ~pwm_d (combinational, used same cycle).
//   Counters per_cnt, hi_cnt: W+2 bits each.
//   FSM SEEK: counters held at 0; idle_cnt counts clocks; on rise -> RUN,
//     per_cnt<=1, hi_cnt<=1, no valid (first edge after reset/timeout only arms).
//     idle_cnt reaching TIMEOUT in SEEK -> timeout action (below), stays SEEK.
//   FSM RUN, each clock without rise: per_cnt+=1, hi_cnt+=pwm_s.
//   RUN on rise: period<=per_cnt; duty<=min(hi_cnt, 2**W-1); stuck<=0;
//     valid<=1 next cycle only; per_cnt<=1, hi_cnt<=1 (rise cycle opens new frame).
//   Timeout: per_cnt (RUN) or idle_cnt (SEEK) == TIMEOUT and no rise that cycle
//     -> duty <= pwm_s ? 2**W-1 : 0; period<=0; stuck<=1; valid<=1;
//     state->SEEK; counters and idle_cnt cleared; repeats every TIMEOUT clocks
//     while the line stays static. Rise and timeout same cycle: rise wins.
//   valid is registered, never high two cycles in a row.
//   Latency: first clk edge sampling pwm_in high -> valid high after
//     SYNC_STAGES+1 edges. Outputs hold between strobes.
//   Frame of 2**W clocks with high H clocks reports duty=H, period=2**W.
// TESTING
//   1 Period 256, high 64, 4 frames -> from 2nd rise: valid each 256 clks, duty=64, period=256, stuck=0.
//   2 Period 256, high 255 then 1 -> duty=255, period=256; next frame high 1 -> duty=1.
//   3 Period 300, high 280 -> duty=255 (saturated), period=300.
//   4 pwm_in held 0 after reset -> valid at clk 512, duty=0, stuck=1; again at 1024;
//     then 256/128 PWM -> first rise arms, 2nd rise valid, duty=128, stuck=0.
//   5 pwm_in held 1 after a running frame -> timeout valid, duty=255, stuck=1.
//   6 rst asserted mid-frame for 1 clk -> outputs 0, no valid; first post-reset rise arms only.

Source files
------------

// File: rtl/pwm_duty_capture.sv
// PWM receive decoder: synchronises pwm_in, measures high-time and period of
// each rise-to-rise frame, and reports a stuck line after TIMEOUT idle clocks.
module pwm_duty_capture #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 512
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pwm_in,
    output logic [W-1:0]   duty,
    output logic [W+1:0]   period,
    output logic           valid,
    output logic           stuck
);

    localparam int CW = W + 2;
    localparam logic [CW-1:0] TO_RUN  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_IDLE = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT_LIM = CW'({W{1'b1}});

    typedef enum logic {SEEK, RUN} state_t;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   pwm_s;
    logic                   pwm_d_p1;
    logic                   rise;
    state_t                 state;
    logic [CW-1:0]          per_cnt;
    logic [CW-1:0]          hi_cnt;
    logic [CW-1:0]          idle_cnt;

    function automatic logic [W-1:0] sat_duty(input logic [CW-1:0] v);
        return (v > SAT_LIM) ? {W{1'b1}} : v[W-1:0];
    endfunction

    // Stage p0/p1: synchroniser chain and edge-detect flop
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= '0;
            pwm_d_p1 <= 1'b0;
        end else begin
            sync_p0  <= {sync_p0[SYNC_STAGES-2:0], pwm_in};
            pwm_d_p1 <= pwm_s;
        end
    end

    assign pwm_s = sync_p0[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d_p1;

    // Stage p2: frame measurement FSM with registered reports
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEEK;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            idle_cnt <= '0;
            duty     <= '0;
            period   <= '0;
            valid    <= 1'b0;
            stuck    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                SEEK: begin
                    // First edge only arms; idle_cnt holds clocks already spent idle.
                    if (rise) begin
                        state    <= RUN;
                        per_cnt  <= CW'(1);
                        hi_cnt   <= CW'(1);
                        idle_cnt <= '0;
                    end else if (idle_cnt == TO_IDLE) begin
                        duty     <= pwm_s ? {W{1'b1}} : '0;
                        period   <= '0;
                        stuck    <= 1'b1;
                        valid    <= 1'b1;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (rise) begin
                        period  <= per_cnt;
                        duty    <= sat_duty(hi_cnt);
                        stuck   <= 1'b0;
                        valid   <= 1'b1;
                        per_cnt <= CW'(1);
                        hi_cnt  <= CW'(1);
                    end else if (per_cnt == TO_RUN) begin
                        duty     <= pwm_s ? {W{1'b1}} : '0;
                        period   <= '0;
                        stuck    <= 1'b1;
                        valid    <= 1'b1;
                        state    <= SEEK;
                        per_cnt  <= '0;
                        hi_cnt   <= '0;
                        idle_cnt <= '0;
                    end else begin
                        per_cnt <= per_cnt + CW'(1);
                        hi_cnt  <= hi_cnt + {{(CW-1){1'b0}}, pwm_s};
                    end
                end
                default: state <= SEEK;
            endcase
        end
    end

endmodule
